// File: rtl/vga_rect_filler.sv
// Rectangle fill engine: streams one registered video-memory write per cycle in raster order.
// Define VGA_RECT_FILLER_CLIP_EN to suppress writes that land outside the visible screen.
module vga_rect_filler #(
  parameter int SCREEN_WIDTH  = 320,
  parameter int SCREEN_HEIGHT = 240
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic [8:0] x0,
  input  logic [7:0] y0,
  input  logic [8:0] width,
  input  logic [7:0] height,
  input  logic [2:0] colour_in,
  input  logic       hold,
  output logic [8:0] x,
  output logic [7:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, DRAW, FINISH} state_t;

`ifdef VGA_RECT_FILLER_CLIP_EN
  localparam logic [9:0] SCREEN_W10 = 10'(SCREEN_WIDTH);
  localparam logic [9:0] SCREEN_H10 = 10'(SCREEN_HEIGHT);
`endif

  state_t     state_q, state_d;
  logic [8:0] x0_q, x0_d, w_q, w_d, cx_q, cx_d;
  logic [7:0] y0_q, y0_d, h_q, h_d, cy_q, cy_d;
  logic       shown_q, shown_d;
  logic [8:0] x_d;
  logic [7:0] y_d;
  logic [2:0] colour_d;
  logic       plot_d, busy_d, done_d;

  logic [8:0] bx, ncx;
  logic [7:0] by, ncy;
  logic [9:0] xs, ys;
  logic       last_col, last_row, vis;

  // Candidate dot for the next cycle. shown_q marks that the dot on the outputs
  // went out un-held, so it has been consumed and the raster may advance.
  always_comb begin
    last_col = (cx_q == w_q - 9'd1);
    last_row = (cy_q == h_q - 8'd1);
    bx  = x0_q;
    by  = y0_q;
    ncx = cx_q;
    ncy = cy_q;
    if (state_q == IDLE) begin
      bx  = x0;
      by  = y0;
      ncx = '0;
      ncy = '0;
    end else if (state_q == DRAW && shown_q) begin
      if (last_col) begin
        ncx = '0;
        ncy = cy_q + 8'd1;
      end else begin
        ncx = cx_q + 9'd1;
      end
    end
    xs = {1'b0, bx} + {1'b0, ncx};
    ys = {2'b0, by} + {2'b0, ncy};
`ifdef VGA_RECT_FILLER_CLIP_EN
    vis = (xs < SCREEN_W10) && (ys < SCREEN_H10);
`else
    vis = 1'b1;
`endif
  end

  always_comb begin
    state_d  = state_q;
    x0_d     = x0_q;
    y0_d     = y0_q;
    w_d      = w_q;
    h_d      = h_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    shown_d  = shown_q;
    x_d      = x;
    y_d      = y;
    colour_d = colour;
    plot_d   = 1'b0;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          x0_d     = x0;
          y0_d     = y0;
          w_d      = width;
          h_d      = height;
          colour_d = colour_in;
          busy_d   = 1'b1;
          if (width == '0 || height == '0) begin
            state_d = FINISH;
            done_d  = 1'b1;
          end else begin
            state_d = DRAW;
            cx_d    = '0;
            cy_d    = '0;
            x_d     = xs[8:0];
            y_d     = ys[7:0];
            shown_d = ~hold;
            plot_d  = ~hold & vis;
          end
        end
      end
      DRAW: begin
        busy_d = 1'b1;
        if (shown_q && last_col && last_row) begin
          state_d = FINISH;
          done_d  = 1'b1;
          shown_d = 1'b0;
        end else begin
          cx_d    = ncx;
          cy_d    = ncy;
          x_d     = xs[8:0];
          y_d     = ys[7:0];
          shown_d = ~hold;
          plot_d  = ~hold & vis;
        end
      end
      FINISH:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      x0_q    <= '0;
      y0_q    <= '0;
      w_q     <= '0;
      h_q     <= '0;
      cx_q    <= '0;
      cy_q    <= '0;
      shown_q <= 1'b0;
      x       <= '0;
      y       <= '0;
      colour  <= '0;
      plot    <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      w_q     <= w_d;
      h_q     <= h_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      shown_q <= shown_d;
      x       <= x_d;
      y       <= y_d;
      colour  <= colour_d;
      plot    <= plot_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule

// File: tb/tb_vga_rect_filler.sv
// Scoreboarded bench for vga_rect_filler: stimulus pushes the expected dot stream,
// a negedge monitor pops and compares every plot/done the DUT presents.
module tb_vga_rect_filler;
  localparam int SW = 320;
  localparam int SH = 240;

  logic       clock = 1'b0;
  logic       reset, start, hold, plot, busy, done;
  logic [8:0] x0, width, x;
  logic [7:0] y0, height, y;
  logic [2:0] colour_in, colour;

  vga_rect_filler #(.SCREEN_WIDTH(SW), .SCREEN_HEIGHT(SH)) dut (
    .clock(clock), .reset(reset), .start(start), .x0(x0), .y0(y0),
    .width(width), .height(height), .colour_in(colour_in), .hold(hold),
    .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  typedef struct {bit is_done; int px; int py; int pc;} exp_t;
  exp_t sbq[$];
  exp_t mon_e;
  int tests = 0, fails = 0;
  int tp[0:63], tx[0:63], ty[0:63], tbz[0:63], td[0:63];

  task automatic chk(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d, want %0d", nm, act, expv);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected writes of one accepted fill, straight from the raster rule.
  task automatic push_fill(input int ax, input int ay, input int aw, input int ah, input int ac);
    for (int yy = 0; yy < ah; yy++)
      for (int xx = 0; xx < aw; xx++) begin
        int px, py;
        px = ax + xx;
        py = ay + yy;
`ifdef VGA_RECT_FILLER_CLIP_EN
        if (px < SW && py < SH) sbq.push_back('{1'b0, px, py, ac});
`else
        sbq.push_back('{1'b0, px % 512, py % 256, ac});
`endif
      end
    sbq.push_back('{1'b1, 0, 0, 0});
  endtask

  always @(negedge clock) begin
    if (plot) begin
      int ok;
      ok = (sbq.size() != 0 && !sbq[0].is_done) ? 1 : 0;
      chk("plot_expected", ok, 1);
      if (ok == 1) begin
        mon_e = sbq.pop_front();
        chk("dot_x", int'(x), mon_e.px);
        chk("dot_y", int'(y), mon_e.py);
        chk("dot_colour", int'(colour), mon_e.pc);
      end
      chk("plot_busy", int'(busy), 1);
    end
    if (done) begin
      int ok;
      ok = (sbq.size() != 0 && sbq[0].is_done) ? 1 : 0;
      chk("done_expected", ok, 1);
      if (ok == 1) void'(sbq.pop_front());
      chk("done_busy", int'(busy), 1);
    end
  end

  // Records cycles 1..n after a start; hmask[k] is the hold level seen by the
  // edge that produces cycle k.
  task automatic trace(input int ax, input int ay, input int aw, input int ah, input int ac,
                       input int n, input int hmask);
    push_fill(ax, ay, aw, ah, ac);
    x0 = 9'(ax); y0 = 8'(ay); width = 9'(aw); height = 8'(ah); colour_in = 3'(ac);
    start = 1'b1;
    hold = hmask[1];
    tick();
    start = 1'b0;
    for (int k = 1; k <= n; k++) begin
      tp[k] = int'(plot); tx[k] = int'(x); ty[k] = int'(y);
      tbz[k] = int'(busy); td[k] = int'(done);
      hold = hmask[k+1];
      if (k < n) tick();
    end
    hold = 1'b0;
    tick();
  endtask

  task automatic rand_fill();
    int ax, ay, aw, ah, ac, cyc;
    ax = $urandom_range(0, 511); ay = $urandom_range(0, 255);
    aw = $urandom_range(0, 6);   ah = $urandom_range(0, 4);
    ac = $urandom_range(0, 7);
    push_fill(ax, ay, aw, ah, ac);
    x0 = 9'(ax); y0 = 8'(ay); width = 9'(aw); height = 8'(ah); colour_in = 3'(ac);
    start = 1'b1;
    hold = ($urandom_range(0, 3) == 0);
    tick();
    start = 1'b0;
    cyc = 0;
    while (done !== 1'b1 && cyc < 300) begin
      hold = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 4) == 0) begin
        start = 1'b1;
        x0 = 9'($urandom_range(0, 511)); width = 9'($urandom_range(1, 9));
        height = 8'($urandom_range(1, 9)); colour_in = 3'($urandom_range(0, 7));
      end
      tick();
      start = 1'b0;
      cyc++;
    end
    chk("fill_done_seen", int'(done === 1'b1), 1);
    // A start on the done cycle must be dropped.
    start = 1'($urandom_range(0, 1));
    width = 9'($urandom_range(1, 9)); height = 8'($urandom_range(1, 9));
    hold = 1'($urandom_range(0, 1));
    tick();
    start = 1'b0;
    hold = 1'b0;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; hold = 1'b0;
    x0 = '0; y0 = '0; width = '0; height = '0; colour_in = '0;
    tick(); tick();
    chk("rst_plot", int'(plot), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_x", int'(x), 0);
    chk("rst_y", int'(y), 0);
    chk("rst_colour", int'(colour), 0);
    reset = 1'b0;
    tick();

    // 3x2 at (10,20)
    trace(10, 20, 3, 2, 5, 8, 0);
    for (int k = 1; k <= 6; k++) begin
      chk("r30_plot", tp[k], 1);
      chk("r30_x", tx[k], 10 + (k - 1) % 3);
      chk("r30_y", ty[k], 20 + (k - 1) / 3);
      chk("r30_done_low", td[k], 0);
    end
    chk("r30_plot7", tp[7], 0);
    chk("r30_done7", td[7], 1);
    for (int k = 1; k <= 7; k++) chk("r30_busy", tbz[k], 1);
    chk("r30_busy8", tbz[8], 0);
    chk("r30_done8", td[8], 0);

    // zero-width fill
    trace(7, 7, 0, 5, 2, 2, 0);
    chk("r31_plot", tp[1], 0);
    chk("r31_done", td[1], 1);
    chk("r31_busy1", tbz[1], 1);
    chk("r31_busy2", tbz[2], 0);
    chk("r31_done2", td[2], 0);

    // hold on cycles 2-3
    trace(0, 0, 4, 1, 3, 7, 32'b1100);
    begin
      int ep[1:7] = '{1, 0, 0, 1, 1, 1, 0};
      int ex[1:6] = '{0, 1, 1, 1, 2, 3};
      for (int k = 1; k <= 7; k++) chk("r32_plot", tp[k], ep[k]);
      for (int k = 1; k <= 6; k++) chk("r32_x", tx[k], ex[k]);
      chk("r32_done", td[7], 1);
    end

    // right-edge fill
    trace(318, 0, 4, 1, 6, 5, 0);
    for (int k = 1; k <= 4; k++) begin
      chk("r33_x", tx[k], 317 + k);
`ifdef VGA_RECT_FILLER_CLIP_EN
      chk("r33_plot", tp[k], (k <= 2) ? 1 : 0);
`else
      chk("r33_plot", tp[k], 1);
`endif
    end
    chk("r33_done", td[5], 1);

    // reset mid-fill
    push_fill(1, 1, 100, 100, 4);
    x0 = 9'd1; y0 = 8'd1; width = 9'd100; height = 8'd100; colour_in = 3'd4;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 1; k < 50; k++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sbq.delete();
    chk("r34_busy", int'(busy), 0);
    chk("r34_plot", int'(plot), 0);
    chk("r34_done", int'(done), 0);
    chk("r34_x", int'(x), 0);
    chk("r34_y", int'(y), 0);
    trace(5, 5, 2, 2, 6, 6, 0);
    chk("r34_new_plot", tp[1], 1);
    chk("r34_new_x", tx[1], 5);
    chk("r34_new_y", ty[1], 5);
    chk("r34_new_done", td[5], 1);

    for (int i = 0; i < 40; i++) rand_fill();

    repeat (4) tick();
    chk("scoreboard_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
